gost89_cfb_decrypt: RTL and testbench
=====================================

Name: gost89_cfb_decrypt

Overview:
- GOST 28147-89 cipher-feedback (CFB) decryptor. It is the receive-side counterpart of the team's CFB encrypt path and sits beside gost89_ecb_encrypt and gost89_ecb_decrypt in the cipher library.
- Each 64-bit ciphertext block is processed as follows:
  - The feedback register (IV or previous ciphertext) goes through the forward 32-round GOST transform.
  - The result is XORed with the ciphertext to give plaintext.
  - The ciphertext becomes the next feedback value.
- The block-transform result is bit-identical to gost89_ecb_encrypt for the same sbox, key and input formats.

Parameters:
- ROUNDS, 32, number of Feistel rounds. Fixed by the standard; exposed only for bench visibility.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load_iv  input  1  single-cycle pulse: latch iv into the feedback register.
- iv  input  64  initialisation vector.
- load_data  input  1  single-cycle pulse: start decrypting in.
- sbox  input  512  substitution table, same packing as the ECB cores.
- key  input  256  key K0..K7, same packing as the ECB cores.
- in  input  64  ciphertext block.
- out  output  64  plaintext block, registered.
- busy  output  1  high while rounds are in progress.
- valid  output  1  one-cycle pulse when out is updated.

Behaviour:
- Reset (reset low, asynchronous): out=0, busy=0, valid=0, feedback=0, round counter=0, captured ciphertext=0, FSM in IDLE. Reset dominates every other input, including load pulses in the same cycle.
- FSM states: IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - load_iv sampled high: feedback <= iv.
  - load_data sampled high: N1/N2 <= halves of the feedback register; ct <= in; counter <= 0; go to ROUND; busy rises at that edge.
  - load_iv and load_data high at the same edge: iv, not the old feedback, is the block input for this transform. feedback is also set to iv.
- ROUND:
  - One round per cycle: sum = N1 + Kidx mod 2^32; 8 nibble S-box lookups; rotate left 11; XOR into N2; swap halves. The swap is omitted on round 31.
  - Key index: rounds 0-23 use i mod 8; rounds 24-31 use 7-(i mod 8).
  - The counter is 5 bits and wraps on the 32nd increment into DONE.
  - load_data and load_iv are ignored while busy; feedback is not disturbed.
- DONE (1 cycle):
  - out <= transform result XOR ct; feedback <= ct; valid=1; busy=0; return to IDLE.
  - Total latency: load edge t0 -> out and valid at edge t0+33. busy is high for exactly 32 cycles.
- Back-to-back operation: a load_data asserted during DONE is ignored. A new load is accepted from IDLE, i.e. the earliest is the edge after valid.
- out holds its value until the next DONE or reset.
- Reset mid-operation aborts the block, clears the feedback chain, and leaves out=0. The user must reload the IV.

Decomposition:
- Shared package gost89_pkg:
  - Constant GOST89_ROUNDS=32.
  - Widths BLOCK_W=64, KEY_W=256, SBOX_W=512.
  - Key-schedule index function for the encrypt direction.
  - Nibble-extraction helper for sbox packing.
- Sub-module gost89_round: combinational single round. Inputs N1, N2, 32-bit subkey, sbox, last-round flag; outputs next N1/N2. It is reused by future CFB encrypt and MAC blocks.
- This module owns the FSM, counter, feedback, ct and output registers.

Test Plan:
1. Basic decrypt (key and sbox as in the ECB bench): load_iv with iv=d5a8a608f4f115b4, then load_data with in=389eb44a391474c4 -> at t0+33, out=eec6172128db322f and valid pulses once; busy is high for 32 cycles.
2. Chaining (continues from 1): load_data with in=7aea1ed18e604249 -> out=0000000000000000, confirming feedback=previous ciphertext.
3. Simultaneous load_iv and load_data at the same edge, iv=d5a8a608f4f115b4, in=d658a36b11cf46eb -> out=0000000000000000.
4. Ignored load while busy: repeat 1, and pulse load_data with in=0123456789abcdef 10 cycles after start -> out=eec6172128db322f at t0+33. A following load_data with in=7aea1ed18e604249 still yields 0000000000000000.
5. Reset mid-operation: reset low for 1 cycle, 6 cycles into a block -> busy=0, out=0, valid never pulses. Re-running scenario 1 then gives eec6172128db322f.
6. Reset asserted together with load_iv and load_data -> nothing latched; busy stays 0. A following load_data with in=389eb44a391474c4 (feedback=0) completes in 33 cycles with valid=1.

Source files
------------

// File: rtl/gost89_pkg.sv
// gost89_pkg: shared GOST 28147-89 widths, FSM states and key/sbox helpers
package gost89_pkg;
  localparam int GOST89_ROUNDS = 32;
  localparam int BLOCK_W = 64;
  localparam int KEY_W = 256;
  localparam int SBOX_W = 512;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  // Encrypt direction: K0..K7 three times, then K7..K0
  function automatic logic [2:0] key_idx(input logic [4:0] i);
    return (i < 5'd24) ? i[2:0] : ~i[2:0];
  endfunction
  // Row r entry v lives at bits (r*16+v)*4 +: 4
  function automatic logic [3:0] sbox_nib(input logic [SBOX_W-1:0] sbox, input logic [2:0] row, input logic [3:0] v);
    return sbox[{row, v, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/gost89_round.sv
// gost89_round: one combinational GOST Feistel round; the final round keeps the halves in place
module gost89_round
  import gost89_pkg::*;
(
  input  logic [31:0]       n1,
  input  logic [31:0]       n2,
  input  logic [31:0]       k,
  input  logic [SBOX_W-1:0] sbox,
  input  logic              last,
  output logic [31:0]       n1_next,
  output logic [31:0]       n2_next
);
  logic [31:0] sum, sub, f;
  assign sum = n1 + k;
  for (genvar i = 0; i < 8; i++) begin : g_sbox
    assign sub[4*i +: 4] = sbox_nib(sbox, 3'(i), sum[4*i +: 4]);
  end
  assign f = {sub[20:0], sub[31:21]};
  assign n1_next = last ? n1 : n2 ^ f;
  assign n2_next = last ? n2 ^ f : n1;
endmodule

// File: rtl/gost89_cfb_decrypt.sv
// gost89_cfb_decrypt: GOST 28147-89 CFB decryptor, one Feistel round per cycle
module gost89_cfb_decrypt
  import gost89_pkg::*;
#(
  parameter int ROUNDS = GOST89_ROUNDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_iv,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               load_data,
  input  logic [SBOX_W-1:0]  sbox,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] in,
  output logic [BLOCK_W-1:0] out,
  output logic               busy,
  output logic               valid
);
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);
  state_t state, state_n;
  logic [4:0] cnt;
  logic [31:0] n1, n2, n1_next, n2_next;
  logic [BLOCK_W-1:0] fb, ct;
  gost89_round u_round (
    .n1(n1),
    .n2(n2),
    .k(key[{key_idx(cnt), 5'b00000} +: 32]),
    .sbox(sbox),
    .last(cnt == LAST),
    .n1_next(n1_next),
    .n2_next(n2_next)
  );
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && load_data) ? ROUND :
              (state == ROUND && cnt == LAST) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      n1 <= '0;
      n2 <= '0;
      fb <= '0;
      ct <= '0;
      out <= '0;
      busy <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == ROUND;
      valid <= state == DONE;
      if (state == IDLE && load_iv) fb <= iv;
      // A same-edge iv load feeds the transform directly
      if (state == IDLE && load_data) begin
        {n1, n2} <= load_iv ? iv : fb;
        ct <= in;
        cnt <= '0;
      end
      if (state == ROUND) begin
        n1 <= n1_next;
        n2 <= n2_next;
        cnt <= cnt + 5'd1;
      end
      if (state == DONE) begin
        out <= {n1, n2} ^ ct;
        fb <= ct;
      end
    end
  end
endmodule

// File: tb/tb_gost89_cfb_decrypt.sv
// tb_gost89_cfb_decrypt: directed scenarios for the CFB decryptor with a reference transform
module tb_gost89_cfb_decrypt;
  localparam logic [63:0] IV0 = 64'hd5a8a608f4f115b4;
  localparam logic [63:0] CT1 = 64'h389eb44a391474c4;
  localparam logic [63:0] JUNK = 64'h0123456789abcdef;
  localparam logic [255:0] KEY = 256'hffeeddcc_bbaa9988_77665544_33221100_f0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff;
  localparam logic [511:0] SBOX = {64'hc8b6e3294a750df1, 64'hc2867ea095f314bd, 64'hefc95863d1270ab4,
                                   64'h2b30e9a48df517c6, 64'h352bc64ef9801ad7, 64'hb9067cfe243ad185,
                                   64'h95701832afd6c4be, 64'h35f7c1b6e08d29a4};
  logic clk = 0, reset = 0, load_iv = 0, load_data = 0;
  logic [63:0] iv = '0, din = '0, dout;
  logic [511:0] sbox = SBOX;
  logic [255:0] key = KEY;
  logic busy, valid;
  int errors = 0, checks = 0;
  int bn, vc, ve;
  logic [63:0] o, exp_v, ct2;

  gost89_cfb_decrypt dut (
    .clk(clk), .reset(reset), .load_iv(load_iv), .iv(iv), .load_data(load_data),
    .sbox(sbox), .key(key), .in(din), .out(dout), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  // Textbook form: swap on every round, then undo the final swap on output
  function automatic logic [63:0] gost_ref(input logic [63:0] blk, input logic [255:0] k, input logic [511:0] s);
    logic [31:0] a, b, t, sum, sub;
    int ki;
    a = blk[63:32];
    b = blk[31:0];
    for (int r = 0; r < 32; r++) begin
      ki = (r < 24) ? r % 8 : 7 - r % 8;
      sum = a + k[ki*32 +: 32];
      for (int j = 0; j < 8; j++) sub[j*4 +: 4] = s[(j*16 + int'(sum[j*4 +: 4]))*4 +: 4];
      t = b ^ ((sub << 11) | (sub >> 21));
      b = a;
      a = t;
    end
    return {b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_iv(input logic [63:0] v);
    load_iv = 1;
    iv = v;
    tick();
    load_iv = 0;
  endtask

  // Starts one block and watches 40 edges; inj/rst_at are cycle offsets (-1 = unused)
  task automatic do_block(input logic [63:0] ct, input logic with_iv, input logic [63:0] ivv,
                          input int inj, input int rst_at,
                          output int busy_n, output int vcnt, output int vedge, output logic [63:0] q);
    busy_n = 0;
    vcnt = 0;
    vedge = -1;
    q = dout;
    load_data = 1;
    din = ct;
    load_iv = with_iv;
    iv = ivv;
    tick();
    load_data = 0;
    load_iv = 0;
    for (int c = 0; c <= 40; c++) begin
      if (busy) busy_n++;
      if (valid) begin
        vcnt++;
        if (vedge < 0) vedge = c;
        q = dout;
      end
      if (c == inj + 1) load_data = 0;
      if (c == inj) begin
        load_data = 1;
        din = JUNK;
      end
      if (c == rst_at + 1) reset = 1;
      if (c == rst_at) reset = 0;
      if (c < 40) tick();
    end
  endtask

  task automatic test_reset();
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (dout !== 64'h0) begin errors++; $display("FAIL reset_out: got %h want 0", dout); end
  endtask

  task automatic test_zero_sbox();
    sbox = '0;
    pulse_iv(64'h0123456789abcdef);
    do_block(64'h0, 0, 0, -1, -1, bn, vc, ve, o);
    checks += 4;
    if (o !== 64'h89abcdef01234567) begin errors++; $display("FAIL zero_sbox_out: got %h want 89abcdef01234567", o); end
    if (ve !== 33) begin errors++; $display("FAIL zero_sbox_latency: got %0d want 33", ve); end
    if (bn !== 32) begin errors++; $display("FAIL zero_sbox_busy: got %0d want 32", bn); end
    if (vc !== 1) begin errors++; $display("FAIL zero_sbox_valid_count: got %0d want 1", vc); end
    do_block(64'hfedcba9876543210, 0, 0, -1, -1, bn, vc, ve, o);
    checks++;
    if (o !== 64'hfedcba9876543210) begin errors++; $display("FAIL zero_sbox_chain: got %h want fedcba9876543210", o); end
    sbox = SBOX;
  endtask

  task automatic test_basic();
    pulse_iv(IV0);
    do_block(CT1, 0, 0, -1, -1, bn, vc, ve, o);
    exp_v = gost_ref(IV0, KEY, SBOX) ^ CT1;
    checks += 5;
    if (o !== exp_v) begin errors++; $display("FAIL basic_out: got %h want %h", o, exp_v); end
    if (ve !== 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", ve); end
    if (bn !== 32) begin errors++; $display("FAIL basic_busy: got %0d want 32", bn); end
    if (vc !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d want 1", vc); end
    if (dout !== exp_v) begin errors++; $display("FAIL basic_hold: got %h want %h", dout, exp_v); end
  endtask

  task automatic test_chaining();
    ct2 = gost_ref(CT1, KEY, SBOX);
    do_block(ct2, 0, 0, -1, -1, bn, vc, ve, o);
    checks++;
    if (o !== 64'h0) begin errors++; $display("FAIL chain_out: got %h want 0", o); end
    do_block(64'h7aea1ed18e604249, 0, 0, -1, -1, bn, vc, ve, o);
    exp_v = gost_ref(ct2, KEY, SBOX) ^ 64'h7aea1ed18e604249;
    checks++;
    if (o !== exp_v) begin errors++; $display("FAIL chain2_out: got %h want %h", o, exp_v); end
  endtask

  task automatic test_simultaneous();
    pulse_iv(64'h0);
    do_block(gost_ref(IV0, KEY, SBOX), 1, IV0, -1, -1, bn, vc, ve, o);
    checks += 2;
    if (o !== 64'h0) begin errors++; $display("FAIL simul_out: got %h want 0", o); end
    if (ve !== 33) begin errors++; $display("FAIL simul_latency: got %0d want 33", ve); end
  endtask

  task automatic test_busy_ignore();
    pulse_iv(IV0);
    do_block(CT1, 0, 0, 10, -1, bn, vc, ve, o);
    exp_v = gost_ref(IV0, KEY, SBOX) ^ CT1;
    checks += 3;
    if (o !== exp_v) begin errors++; $display("FAIL ignore_out: got %h want %h", o, exp_v); end
    if (bn !== 32) begin errors++; $display("FAIL ignore_busy: got %0d want 32", bn); end
    if (vc !== 1) begin errors++; $display("FAIL ignore_valid_count: got %0d want 1", vc); end
    do_block(gost_ref(CT1, KEY, SBOX), 0, 0, -1, -1, bn, vc, ve, o);
    checks++;
    if (o !== 64'h0) begin errors++; $display("FAIL ignore_chain: got %h want 0", o); end
  endtask

  task automatic test_back_to_back();
    pulse_iv(IV0);
    do_block(CT1, 0, 0, 32, -1, bn, vc, ve, o);
    exp_v = gost_ref(IV0, KEY, SBOX) ^ CT1;
    checks += 3;
    if (o !== exp_v) begin errors++; $display("FAIL b2b_out: got %h want %h", o, exp_v); end
    if (bn !== 32) begin errors++; $display("FAIL b2b_busy: got %0d want 32", bn); end
    if (vc !== 1) begin errors++; $display("FAIL b2b_valid_count: got %0d want 1", vc); end
  endtask

  task automatic test_reset_mid();
    pulse_iv(IV0);
    do_block(CT1, 0, 0, -1, 6, bn, vc, ve, o);
    checks += 3;
    if (vc !== 0) begin errors++; $display("FAIL rstmid_valid_count: got %0d want 0", vc); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (dout !== 64'h0) begin errors++; $display("FAIL rstmid_out: got %h want 0", dout); end
    pulse_iv(IV0);
    do_block(CT1, 0, 0, -1, -1, bn, vc, ve, o);
    exp_v = gost_ref(IV0, KEY, SBOX) ^ CT1;
    checks++;
    if (o !== exp_v) begin errors++; $display("FAIL rstmid_rerun: got %h want %h", o, exp_v); end
  endtask

  task automatic test_reset_with_load();
    reset = 0;
    load_iv = 1;
    load_data = 1;
    iv = IV0;
    din = JUNK;
    tick();
    reset = 1;
    load_iv = 0;
    load_data = 0;
    tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstload_busy: got %b want 0", busy); end
    if (dout !== 64'h0) begin errors++; $display("FAIL rstload_out: got %h want 0", dout); end
    do_block(CT1, 0, 0, -1, -1, bn, vc, ve, o);
    exp_v = gost_ref(64'h0, KEY, SBOX) ^ CT1;
    checks += 3;
    if (o !== exp_v) begin errors++; $display("FAIL rstload_out2: got %h want %h", o, exp_v); end
    if (ve !== 33) begin errors++; $display("FAIL rstload_latency: got %0d want 33", ve); end
    if (vc !== 1) begin errors++; $display("FAIL rstload_valid_count: got %0d want 1", vc); end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    reset = 1;
    tick();
    test_zero_sbox();
    test_basic();
    test_chaining();
    test_simultaneous();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
